// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, imem req/ack handshake, IR hold for decode
// Redirects are taken at once; a fetch already on the bus is finished in DROP and its data thrown away.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        dec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] ir_q;
  logic [31:0] ir_pc_q;
  logic        ir_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      ir_q       <= 32'h0;
      ir_pc_q    <= 32'h0;
      ir_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      ir_valid_q <= 1'b0;
      case (state_q)
        IDLE, HOLD: begin
          if (fetch_en) begin
            state_q <= FETCH;
            addr_q  <= redirect_pc;
          end else begin
            state_q <= IDLE;
          end
        end
        // A request on the bus must complete on its original address.
        FETCH, DROP: begin
          if (imem_ack) begin
            state_q <= FETCH;
            addr_q  <= redirect_pc;
          end else begin
            state_q <= DROP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en) begin
            state_q <= FETCH;
            addr_q  <= pc_q;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            ir_q       <= imem_rdata;
            ir_pc_q    <= addr_q;
            ir_valid_q <= 1'b1;
            pc_q       <= pc_q + PC_STEP;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (dec_ready) begin
            ir_valid_q <= 1'b0;
            if (fetch_en) begin
              state_q <= FETCH;
              addr_q  <= pc_q;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            if (fetch_en) begin
              state_q <= FETCH;
              addr_q  <= pc_q;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr = addr_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch
// Second instance with RESET_PC=32'hFFFF_FFFF covers PC wrap and async reset mid-request.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, imem_ack, dec_ready, redirect_valid;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, ir_valid;
  logic [31:0] imem_addr, ir, ir_pc;

  logic        w_fetch_en, w_imem_ack, w_dec_ready;
  logic [31:0] w_imem_rdata;
  logic        w_imem_req, w_ir_valid;
  logic [31:0] w_imem_addr, w_ir, w_ir_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .dec_ready(dec_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .fetch_en(w_fetch_en),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
    .ir(w_ir), .ir_pc(w_ir_pc), .ir_valid(w_ir_valid), .dec_ready(w_dec_ready),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    fetch_en = 0; imem_ack = 0; dec_ready = 0; redirect_valid = 0;
    imem_rdata = 0; redirect_pc = 0;
    w_fetch_en = 0; w_imem_ack = 0; w_dec_ready = 0; w_imem_rdata = 0;
    tick; tick;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b exp 0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    total++; if (ir !== 32'h0) begin bad++; $display("FAIL reset_ir got %h exp 0", ir); end
    total++; if (ir_pc !== 32'h0) begin bad++; $display("FAIL reset_ir_pc got %h exp 0", ir_pc); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", ir_valid); end
    total++; if (w_imem_addr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_w_addr got %h exp ffffffff", w_imem_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch;
    fetch_en = 1;
    tick;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h0800_0005;
    tick;
    imem_ack = 0;
    total++; if (ir !== 32'h0800_0005) begin bad++; $display("FAIL first_ir got %h exp 08000005", ir); end
    total++; if (ir_pc !== 32'h0 || ir_valid !== 1'b1) begin bad++; $display("FAIL first_irpc got pc=%h v=%b exp 0/1", ir_pc, ir_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req got %b exp 0", imem_req); end
  endtask

  task automatic test_hold_stall;
    dec_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if (ir !== 32'h0800_0005 || ir_pc !== 32'h0 || ir_valid !== 1'b1 || imem_req !== 1'b0) begin
        bad++; $display("FAIL stall_%0d got ir=%h pc=%h v=%b req=%b exp 08000005/0/1/0", i, ir, ir_pc, ir_valid, imem_req);
      end
    end
    dec_ready = 1;
    tick;
    dec_ready = 0;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL consume_valid got %b exp 0", ir_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h1) begin bad++; $display("FAIL next_req got req=%b addr=%h exp 1/1", imem_req, imem_addr); end
  endtask

  task automatic advance_to_addr3;
    imem_ack = 1; imem_rdata = 32'h11;
    tick;
    imem_ack = 0; dec_ready = 1;
    tick;
    dec_ready = 0; imem_ack = 1; imem_rdata = 32'h22;
    tick;
    imem_ack = 0;
    total++; if (ir !== 32'h22 || ir_pc !== 32'h2) begin bad++; $display("FAIL ir_addr2 got ir=%h pc=%h exp 22/2", ir, ir_pc); end
    dec_ready = 1;
    tick;
    dec_ready = 0;
    total++; if (imem_addr !== 32'h3 || imem_req !== 1'b1) begin bad++; $display("FAIL req_addr3 got addr=%h req=%b exp 3/1", imem_addr, imem_req); end
  endtask

  task automatic test_redirect_pending;
    redirect_valid = 1; redirect_pc = 32'h40;
    tick;
    redirect_valid = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_addr !== 32'h3 || imem_req !== 1'b1 || ir_valid !== 1'b0) begin
        bad++; $display("FAIL drop_wait_%0d got addr=%h req=%b v=%b exp 3/1/0", i, imem_addr, imem_req, ir_valid);
      end
      if (i < 2) tick;
    end
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_ack = 0;
    total++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin bad++; $display("FAIL after_drop_addr got addr=%h req=%b exp 40/1", imem_addr, imem_req); end
    total++; if (ir_valid !== 1'b0 || ir !== 32'h22) begin bad++; $display("FAIL drop_discard got v=%b ir=%h exp 0/22", ir_valid, ir); end
  endtask

  task automatic test_redirect_with_ack;
    imem_ack = 1; imem_rdata = 32'hBAD0_BAD0; redirect_valid = 1; redirect_pc = 32'h80;
    tick;
    imem_ack = 0; redirect_valid = 0;
    total++; if (imem_addr !== 32'h80 || imem_req !== 1'b1) begin bad++; $display("FAIL redir_ack_addr got addr=%h req=%b exp 80/1", imem_addr, imem_req); end
    total++; if (ir_valid !== 1'b0 || ir !== 32'h22) begin bad++; $display("FAIL redir_ack_discard got v=%b ir=%h exp 0/22", ir_valid, ir); end
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    tick;
    imem_ack = 0;
    total++; if (ir !== 32'h1234_5678 || ir_pc !== 32'h80 || ir_valid !== 1'b1) begin bad++; $display("FAIL target_ir got ir=%h pc=%h v=%b exp 12345678/80/1", ir, ir_pc, ir_valid); end
  endtask

  task automatic test_redirect_hold;
    redirect_valid = 1; redirect_pc = 32'h100; dec_ready = 1;
    tick;
    redirect_valid = 0; dec_ready = 0;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL squash_valid got %b exp 0", ir_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL squash_req got req=%b addr=%h exp 1/100", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h5555_AAAA;
    tick;
    imem_ack = 0;
    total++; if (ir_pc !== 32'h100 || ir !== 32'h5555_AAAA) begin bad++; $display("FAIL squash_target got pc=%h ir=%h exp 100/5555aaaa", ir_pc, ir); end
  endtask

  task automatic test_fetch_en_gate;
    fetch_en = 0; dec_ready = 1;
    tick;
    dec_ready = 0;
    total++; if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin bad++; $display("FAIL gate_idle got req=%b v=%b exp 0/0", imem_req, ir_valid); end
    imem_ack = 1; imem_rdata = 32'h7777_7777;
    tick;
    imem_ack = 0;
    total++; if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'h5555_AAAA) begin bad++; $display("FAIL idle_ack got req=%b v=%b ir=%h exp 0/0/5555aaaa", imem_req, ir_valid, ir); end
    fetch_en = 1;
    tick;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h101) begin bad++; $display("FAIL resume got req=%b addr=%h exp 1/101", imem_req, imem_addr); end
  endtask

  task automatic test_wrap_and_async_reset;
    w_fetch_en = 1;
    tick;
    total++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_first got req=%b addr=%h exp 1/ffffffff", w_imem_req, w_imem_addr); end
    w_imem_ack = 1; w_imem_rdata = 32'hCAFE_F00D;
    tick;
    w_imem_ack = 0;
    total++; if (w_ir_pc !== 32'hFFFF_FFFF || w_ir_valid !== 1'b1) begin bad++; $display("FAIL wrap_irpc got pc=%h v=%b exp ffffffff/1", w_ir_pc, w_ir_valid); end
    w_dec_ready = 1;
    tick;
    w_dec_ready = 0;
    total++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_second got req=%b addr=%h exp 1/0", w_imem_req, w_imem_addr); end
    rst_n = 1'b0;
    #1;
    total++; if (w_imem_req !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL async_req got w=%b main=%b exp 0/0", w_imem_req, imem_req); end
    total++; if (w_ir !== 32'h0 || w_ir_pc !== 32'h0 || w_ir_valid !== 1'b0) begin bad++; $display("FAIL async_ir got ir=%h pc=%h v=%b exp 0/0/0", w_ir, w_ir_pc, w_ir_valid); end
    total++; if (w_imem_addr !== 32'hFFFF_FFFF || imem_addr !== 32'h0) begin bad++; $display("FAIL async_addr got w=%h main=%h exp ffffffff/0", w_imem_addr, imem_addr); end
  endtask

  initial begin
    test_reset;
    test_basic_fetch;
    test_hold_stall;
    advance_to_addr3;
    test_redirect_pending;
    test_redirect_with_ack;
    test_redirect_hold;
    test_fetch_en_gate;
    test_wrap_and_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
